// File: rtl/game_pkg.sv
// Shared definitions for the top-level game flow: screen state encoding and
// the one-hot flag decode also used by the renderer's screen selector.
package game_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [2:0] {
    GREETING  = 3'd0,
    PLAYING   = 3'd1,
    PAUSED    = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } game_state_e;

  typedef struct packed {
    logic greeting;
    logic playing;
    logic paused;
    logic level_up;
    logic game_over;
  } screen_flags_t;

  // Unknown encodings decode to the greeting screen so exactly one flag is
  // ever high, matching where the FSM itself recovers to.
  function automatic screen_flags_t decode_flags(input game_state_e s);
    screen_flags_t f;
    f = '0;
    case (s)
      PLAYING:   f.playing   = 1'b1;
      PAUSED:    f.paused    = 1'b1;
      LEVEL_UP:  f.level_up  = 1'b1;
      GAME_OVER: f.game_over = 1'b1;
      default:   f.greeting  = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises an active-low asynchronous board key and emits a one-cycle
// press pulse on each released->pressed transition.
module key_edge_sync (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = key_n;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Reset to the released level so a key held through reset gives no press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign press = s3_q & ~s2_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game flow FSM: greeting / playing / paused / level-up banner /
// game-over, with lives, level progression and win indication.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES       = 3,
  parameter int NUM_LEVELS      = 4,
  parameter int LEVEL_UP_CYCLES = 25000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic                key_start,
  input  logic                key_pause,
  input  logic                collision,
  input  logic                level_done,
  output logic                f_greeting,
  output logic                f_playing,
  output logic                f_paused,
  output logic                f_level_up,
  output logic                f_game_over,
  output logic                win,
  output logic [LIVES_W-1:0]  lives,
  output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] level,
  output logic                state_changed
);

  localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int CNT_W   = $clog2(LEVEL_UP_CYCLES);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LEVEL_UP_CYCLES - 1);

  logic start_press, pause_press;

  key_edge_sync u_start_sync (
    .clock  (clock),
    .resetn (resetn),
    .key_n  (key_start),
    .press  (start_press)
  );

  key_edge_sync u_pause_sync (
    .clock  (clock),
    .resetn (resetn),
    .key_n  (key_pause),
    .press  (pause_press)
  );

  // Events are only acted on while enabled; anything arriving with
  // enable low is dropped, not deferred.
  logic start_ev, pause_ev, col_ev, done_ev;
  assign start_ev = enable & start_press;
  assign pause_ev = enable & pause_press;
  assign col_ev   = enable & collision;
  assign done_ev  = enable & level_done;

  game_state_e          state_q,   state_d;
  logic [LIVES_W-1:0]   lives_q,   lives_d;
  logic [LEVEL_W-1:0]   level_q,   level_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 win_q,     win_d;
  logic                 changed_q, changed_d;
  screen_flags_t        flags_q,   flags_d;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    win_d   = win_q;

    case (state_q)
      GREETING: begin
        if (start_ev) begin
          state_d = PLAYING;
          lives_d = LIVES_INIT;
          level_d = '0;
          win_d   = 1'b0;
        end
      end
      PLAYING: begin
        if (col_ev) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - LIVES_W'(1);
          end else begin
            lives_d = '0;
            win_d   = 1'b0;
            state_d = GAME_OVER;
          end
        end else if (done_ev) begin
          if (level_q == LEVEL_LAST) begin
            state_d = GAME_OVER;
            win_d   = 1'b1;
          end else begin
            state_d = LEVEL_UP;
            cnt_d   = '0;
          end
        end else if (pause_ev) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_ev) state_d = PLAYING;
      end
      LEVEL_UP: begin
        // Banner lasts exactly LEVEL_UP_CYCLES enabled cycles, count 0..LAST.
        if (enable) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PLAYING;
            level_d = level_q + LEVEL_W'(1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GAME_OVER: begin
        if (start_ev) state_d = GREETING;
      end
      default: state_d = GREETING;
    endcase

    flags_d   = decode_flags(state_d);
    changed_d = (state_d != state_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= GREETING;
      lives_q   <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      changed_q <= 1'b0;
      flags_q   <= decode_flags(GREETING);
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      changed_q <= changed_d;
      flags_q   <= flags_d;
    end
  end

  assign f_greeting    = flags_q.greeting;
  assign f_playing     = flags_q.playing;
  assign f_paused      = flags_q.paused;
  assign f_level_up    = flags_q.level_up;
  assign f_game_over   = flags_q.game_over;
  assign win           = win_q;
  assign lives         = lives_q;
  assign level         = level_q;
  assign state_changed = changed_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus random
// stimulus, all compared against a behavioural model of the game rules.
module tb_game_state_ctrl;

  localparam int NL  = 3;
  localparam int NLV = 4;
  localparam int LUC = 4;

  logic       clock = 1'b0;
  logic       resetn, enable, key_start, key_pause, collision, level_done;
  logic       f_greeting, f_playing, f_paused, f_level_up, f_game_over, win;
  logic [3:0] lives;
  logic [1:0] level;
  logic       state_changed;

  int checks = 0;
  int errors = 0;

  game_state_ctrl #(
    .NUM_LIVES       (NL),
    .NUM_LEVELS      (NLV),
    .LEVEL_UP_CYCLES (LUC)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .key_start     (key_start),
    .key_pause     (key_pause),
    .collision     (collision),
    .level_done    (level_done),
    .f_greeting    (f_greeting),
    .f_playing     (f_playing),
    .f_paused      (f_paused),
    .f_level_up    (f_level_up),
    .f_game_over   (f_game_over),
    .win           (win),
    .lives         (lives),
    .level         (level),
    .state_changed (state_changed)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  localparam int M_GREET = 0, M_PLAY = 1, M_PAUSE = 2, M_LU = 3, M_GO = 4;

  int       m_mode, m_lives, m_level, m_remain;
  bit       m_win, m_changed;
  bit [2:0] hist_s, hist_p;  // [0] = key level seen at last edge, [2] = three edges ago

  always @(posedge clock or negedge resetn) begin : model
    int nm, nl, nlev, nrem;
    bit nw, sp, pp;
    if (!resetn) begin
      m_mode    <= M_GREET;
      m_lives   <= 0;
      m_level   <= 0;
      m_remain  <= 0;
      m_win     <= 1'b0;
      m_changed <= 1'b0;
      hist_s    <= 3'b111;
      hist_p    <= 3'b111;
    end else begin
      // A press is seen when the key was up three edges ago and down two ago.
      sp   = enable && hist_s[2] && !hist_s[1];
      pp   = enable && hist_p[2] && !hist_p[1];
      nm   = m_mode;
      nl   = m_lives;
      nlev = m_level;
      nrem = m_remain;
      nw   = m_win;
      if (enable) begin
        case (m_mode)
          M_GREET: if (sp) begin nm = M_PLAY; nl = NL; nlev = 0; nw = 1'b0; end
          M_PLAY: begin
            if (collision) begin
              if (m_lives > 1) nl = m_lives - 1;
              else begin nl = 0; nm = M_GO; nw = 1'b0; end
            end else if (level_done) begin
              if (m_level == NLV - 1) begin nm = M_GO; nw = 1'b1; end
              else begin nm = M_LU; nrem = LUC; end
            end else if (pp) nm = M_PAUSE;
          end
          M_PAUSE: if (pp) nm = M_PLAY;
          M_LU: begin
            nrem = m_remain - 1;
            if (nrem == 0) begin nm = M_PLAY; nlev = m_level + 1; end
          end
          M_GO: if (sp) nm = M_GREET;
          default: nm = M_GREET;
        endcase
      end
      m_changed <= (nm != m_mode);
      m_mode    <= nm;
      m_lives   <= nl;
      m_level   <= nlev;
      m_remain  <= nrem;
      m_win     <= nw;
      hist_s    <= {hist_s[1:0], key_start};
      hist_p    <= {hist_p[1:0], key_pause};
    end
  end

  function automatic logic [12:0] obs_vec();
    return {f_greeting, f_playing, f_paused, f_level_up, f_game_over, win,
            lives, level, state_changed};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_mode == M_GREET, m_mode == M_PLAY, m_mode == M_PAUSE,
            m_mode == M_LU, m_mode == M_GO, m_win, 4'(m_lives), 2'(m_level),
            m_changed};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic press(input bit is_start, input bit is_pause, input int low_cyc);
    if (is_start) key_start = 1'b0;
    if (is_pause) key_pause = 1'b0;
    tick(low_cyc);
    key_start = 1'b1;
    key_pause = 1'b1;
  endtask

  task automatic pulse(input bit col, input bit done);
    collision  = col;
    level_done = done;
    tick();
    collision  = 1'b0;
    level_done = 1'b0;
  endtask

  task automatic restart();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    press(1'b1, 1'b0, 2);
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; key_start = 1'b1; key_pause = 1'b1;
    collision = 1'b0; level_done = 1'b0;
    tick(2);
    checks++;
    if (obs_vec() !== 13'b1_0000_0_0000_00_0) begin
      errors++;
      $display("FAIL reset_state: got %b, required %b", obs_vec(), 13'b1_0000_0_0000_00_0);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_start();
    press(1'b1, 1'b0, 2);
    checks++;
    if (f_playing !== 1'b0 || f_greeting !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_early: playing=%b greeting=%b, required 0/1", f_playing, f_greeting);
    end
    tick();
    checks++;
    if ({f_playing, lives, level, state_changed} !== {1'b1, 4'd3, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL start_enter_play: playing=%b lives=%0d level=%0d chg=%b, required 1/3/0/1",
               f_playing, lives, level, state_changed);
    end
    tick();
    checks++;
    if (state_changed !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL start_changed_pulse: got %b, required %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_key_held();
    int pulses = 0;
    int bad = 0;
    resetn = 1'b0; tick(); resetn = 1'b1;
    key_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_changed) pulses++;
      if (obs_vec() !== exp_vec()) bad++;
    end
    key_start = 1'b1;
    tick(3);
    checks++;
    if (pulses != 1 || bad != 0 || f_playing !== 1'b1) begin
      errors++;
      $display("FAIL key_held_single: transitions=%0d model_diffs=%0d playing=%b, required 1/0/1",
               pulses, bad, f_playing);
    end
  endtask

  task automatic test_collisions();
    logic [3:0] exp_q[$];
    exp_q = '{4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      pulse(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (lives !== e || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL collision_%0d: lives=%0d vec=%b, required lives=%0d vec=%b",
                 i, lives, obs_vec(), e, exp_vec());
      end
    end
    checks++;
    if ({f_game_over, win, lives} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL collision_game_over: go=%b win=%b lives=%0d, required 1/0/0",
               f_game_over, win, lives);
    end
    press(1'b1, 1'b0, 2);
    tick();
    checks++;
    if (f_greeting !== 1'b1 || lives !== 4'd0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL game_over_to_greeting: got %b, required %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_level_up();
    restart();
    for (int lv = 0; lv < NLV - 1; lv++) begin
      int n = 0;
      pulse(1'b0, 1'b1);
      while (f_level_up === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      checks++;
      if (n != LUC || f_playing !== 1'b1 || level !== 2'(lv + 1) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL level_up_%0d: banner_cycles=%0d playing=%b level=%0d, required %0d/1/%0d",
                 lv, n, f_playing, level, LUC, lv + 1);
      end
    end
    pulse(1'b0, 1'b1);
    checks++;
    if ({f_game_over, win, level} !== {1'b1, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL last_level_win: go=%b win=%b level=%0d, required 1/1/3", f_game_over, win, level);
    end
  endtask

  task automatic test_pause();
    restart();
    press(1'b0, 1'b1, 2);
    tick();
    checks++;
    if (f_paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_enter: paused=%b, required 1", f_paused);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    press(1'b1, 1'b0, 2);
    tick(2);
    checks++;
    if ({f_paused, lives, level} !== {1'b1, 4'd3, 2'd0} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pause_hold: paused=%b lives=%0d level=%0d, required 1/3/0", f_paused, lives, level);
    end
    press(1'b0, 1'b1, 2);
    tick();
    checks++;
    if (f_playing !== 1'b1 || state_changed !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: playing=%b chg=%b, required 1/1", f_playing, state_changed);
    end
  endtask

  task automatic test_simultaneous();
    restart();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    checks++;
    if ({f_game_over, win, lives} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL collision_beats_done: go=%b win=%b lives=%0d, required 1/0/0", f_game_over, win, lives);
    end
    resetn = 1'b0; tick(); resetn = 1'b1;
    press(1'b1, 1'b1, 2);
    tick();
    checks++;
    if (f_playing !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL both_keys_greeting: got %b, required %b", obs_vec(), exp_vec());
    end
    press(1'b1, 1'b1, 2);
    tick();
    checks++;
    if (f_paused !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL both_keys_playing: got %b, required %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_enable_low();
    resetn = 1'b0; tick(); resetn = 1'b1;
    enable = 1'b0;
    press(1'b1, 1'b0, 2);
    tick(2);
    enable = 1'b1;
    tick(3);
    checks++;
    if (f_greeting !== 1'b1 || state_changed !== 1'b0) begin
      errors++;
      $display("FAIL enable_low_start: greeting=%b chg=%b, required 1/0", f_greeting, state_changed);
    end
    restart();
    enable = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    enable = 1'b1;
    tick();
    checks++;
    if ({f_playing, lives, level} !== {1'b1, 4'd3, 2'd0}) begin
      errors++;
      $display("FAIL enable_low_pulses: playing=%b lives=%0d level=%0d, required 1/3/0", f_playing, lives, level);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    pulse(1'b0, 1'b1);
    tick(2);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 13'b1_0000_0_0000_00_0) begin
      errors++;
      $display("FAIL reset_mid_level_up: got %b, required %b", obs_vec(), 13'b1_0000_0_0000_00_0);
    end
    @(negedge clock);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    int s_hold = 0;
    int p_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (s_hold == 0) begin key_start = ~key_start; s_hold = $urandom_range(1, 12); end
      if (p_hold == 0) begin key_pause = ~key_pause; p_hold = $urandom_range(1, 15); end
      s_hold--;
      p_hold--;
      enable     = ($urandom_range(0, 9) != 0);
      collision  = ($urandom_range(0, 19) == 0);
      level_done = ($urandom_range(0, 14) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %b, required %b", i, obs_vec(), exp_vec());
      end
    end
    key_start = 1'b1; key_pause = 1'b1; enable = 1'b1; collision = 1'b0; level_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_key_held();
    test_collisions();
    test_level_up();
    test_pause();
    test_simultaneous();
    test_enable_low();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised next-generation top-level game FSM driving the greeting/playing/game-over screen flags consumed by the render and logic blocks. It adds on-chip key synchronisation and falling-edge detection, a pause state, multi-level progression with a timed level-up banner, a lives counter, and a win/lose indication. It sits between the board keys, the game-logic event pulses and the VGA screen selectors.

Parameters:
NUM_LIVES, 3, lives loaded on game start (1..15)
NUM_LEVELS, 4, levels per game (1..16); clearing last level is a win
LEVEL_UP_CYCLES, 25000000, clock cycles LEVEL_UP banner is held (>=2)

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  global advance enable; low freezes state, counters, lives, level
key_start  input  1  active-low raw start key (board KEY3), asynchronous
key_pause  input  1  active-low raw pause key, asynchronous
collision  input  1  single-cycle pulse from game logic: life lost
level_done  input  1  single-cycle pulse from game logic: level cleared
f_greeting  output  1  state == GREETING
f_playing  output  1  state == PLAYING
f_paused  output  1  state == PAUSED
f_level_up  output  1  state == LEVEL_UP
f_game_over  output  1  state == GAME_OVER
win  output  1  game ended by clearing last level
lives  output  4  remaining lives
level  output  $clog2(NUM_LEVELS) (min 1)  current level, 0-based
state_changed  output  1  one-cycle pulse in the cycle after any state transition

Behaviour:
- Reset (resetn low, async): state GREETING; f_greeting=1, other flags 0; win=0; lives=0; level=0; state_changed=0; key sync registers to 1 (released); banner counter 0.
- Key path, per key: two-flop synchroniser s1->s2, plus s3 <= s2; press = s3 & ~s2. Key low before edge 1 -> press high after edge 2 -> state updates on edge 3. One press per 1->0 transition; held key produces no repeat. Sync runs regardless of enable; press occurring while enable=0 is discarded.
- All transitions/counter updates qualified by enable=1. collision/level_done ignored when enable=0.
- GREETING: start press -> PLAYING; lives<=NUM_LIVES, level<=0, win<=0. Pause press ignored.
- PLAYING, priority collision > level_done > pause press:
  collision, lives>1 -> lives-1, stay PLAYING;
  collision, lives==1 -> lives<=0, GAME_OVER, win=0;
  level_done, level==NUM_LEVELS-1 -> GAME_OVER, win<=1;
  level_done otherwise -> LEVEL_UP, banner counter <=0;
  pause press -> PAUSED. Start press ignored.
- PAUSED: pause press -> PLAYING. Start, collision, level_done ignored; lives/level held.
- LEVEL_UP: counter increments each enabled cycle; at count LEVEL_UP_CYCLES-1 -> PLAYING, level+1. Exactly LEVEL_UP_CYCLES enabled cycles in LEVEL_UP. All keys and pulses ignored.
- GAME_OVER: start press -> GREETING; win, lives, level held until next game start.
- Flags are registered one-hot decodes of state; exactly one high at all times.
- state_changed: registered, high for exactly one cycle following each transition edge; 0 at reset.
- Simultaneous start and pause press: each handled per current-state rules (only one is ever legal).
- Reset mid-game (any state, any counter value): immediate return to reset values.
- Illegal state encoding -> GREETING next cycle.

Decomposition:
- Shared package game_pkg: state enum (GREETING, PLAYING, PAUSED, LEVEL_UP, GAME_OVER) and encoding, LIVES_W=4; reused by renderer screen selector.
- One sub-module: key_edge_sync (2-flop sync + falling-edge press pulse, async active-low reset to released), instantiated twice.

Test Plan:
- Reset, enable=1, key_start low 20ns then high -> f_playing=1 on 3rd edge after press, lives=3, level=0, state_changed one cycle; key held low 200ns -> single transition only.
- PLAYING, three collision pulses -> lives 2,1 then GAME_OVER with lives=0, win=0; start press -> GREETING.
- PLAYING, LEVEL_UP_CYCLES=4: level_done -> f_level_up high exactly 4 cycles, then PLAYING, level=1; repeat to level 3, level_done -> GAME_OVER, win=1.
- PLAYING, pause press -> PAUSED; collision and level_done during pause -> lives/level unchanged; pause press -> PLAYING.
- Same cycle collision (lives=1) and level_done -> GAME_OVER, win=0; enable=0 with start press -> stays GREETING.
- resetn low mid LEVEL_UP (counter=2) -> all outputs at reset values immediately, f_greeting=1.
